// File: rtl/bitslam_synth_if.sv
// Write bus for the bitslam synthesizer.
//   addr_data_sel : 0 = address write, 1 = data write
//   addr_data     : 6-bit address or data value
// master drives the bus, slave (the synth) samples it.
interface bitslam_synth_if;
    logic       addr_data_sel;
    logic [5:0] addr_data;

    modport master (output addr_data_sel, output addr_data);
    modport slave  (input  addr_data_sel, input  addr_data);
endinterface

// File: rtl/bitslam_synth.sv
// Multi-voice square/noise synthesizer with PWM output.
// Each voice has a clock divider, a phase accumulator, a programmable-duty
// square or 15-bit LFSR noise source and a volume. Voices are summed with
// saturation into a registered sample, which also drives a 1-bit PWM stream.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high
//   bus        : address/data write bus (slave side)
//   sample_out : registered mixed sample
//   pwm_out    : registered PWM of sample_out
//
// Address map: voice = addr[5:2], reg = addr[1:0]
//   0 div_max, 1 volume, 2 mode {enable, noise_sel}, 3 duty
module bitslam_synth #(
    parameter int NUM_VOICES  = 2,
    parameter int DIV_WIDTH   = 6,
    parameter int PHASE_WIDTH = 8,
    parameter int VOL_WIDTH   = 4,
    parameter int OUT_WIDTH   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    bitslam_synth_if.slave       bus,
    output logic [OUT_WIDTH-1:0] sample_out,
    output logic                 pwm_out
);

    localparam logic [31:0] SAT_MAX = 32'((64'd1 << OUT_WIDTH) - 64'd1);

    logic [5:0]           addr;
    logic [OUT_WIDTH-1:0] pwm_cnt;
    logic [OUT_WIDTH-1:0] sample_next;
    logic [31:0]          sum;
    logic [VOL_WIDTH-1:0] contrib [NUM_VOICES];

    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
        end else if (!bus.addr_data_sel) begin
            addr <= bus.addr_data;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic [DIV_WIDTH-1:0]   div_max;
        logic [DIV_WIDTH-1:0]   div_cnt;
        logic [VOL_WIDTH-1:0]   volume;
        logic                   noise_sel;
        logic                   enable;
        logic [5:0]             duty;
        logic [PHASE_WIDTH-1:0] phase;
        logic [14:0]            lfsr;
        logic                   sel;
        logic                   tick;
        logic                   wave;

        // Voice indices >= NUM_VOICES never match any instance, so such
        // writes fall on the floor.
        assign sel  = bus.addr_data_sel && (addr[5:2] == 4'(v));
        // >= rather than == so lowering div_max below the count still ticks.
        assign tick = enable && (div_cnt >= div_max);
        assign wave = noise_sel ? lfsr[0] : (phase[PHASE_WIDTH-1 -: 6] < duty);
        assign contrib[v] = (enable && wave) ? volume : '0;

        always_ff @(posedge clk) begin
            if (reset) begin
                div_max   <= '0;
                div_cnt   <= '0;
                volume    <= '0;
                noise_sel <= 1'b0;
                enable    <= 1'b0;
                duty      <= 6'h20;
                phase     <= '0;
                lfsr      <= 15'h0001;
            end else begin
                if (sel) begin
                    case (addr[1:0])
                        2'd0: div_max <= bus.addr_data[DIV_WIDTH-1:0];
                        2'd1: volume  <= bus.addr_data[VOL_WIDTH-1:0];
                        2'd2: {enable, noise_sel} <= bus.addr_data[1:0];
                        2'd3: duty    <= bus.addr_data;
                    endcase
                end
                // A disabled voice freezes counter, phase and lfsr.
                if (enable) begin
                    if (tick) begin
                        div_cnt <= '0;
                        phase   <= phase + PHASE_WIDTH'(1);
                        lfsr    <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            sum = sum + 32'(contrib[v]);
        end
        sample_next = (sum > SAT_MAX) ? '1 : sum[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out <= '0;
            pwm_cnt    <= '0;
            pwm_out    <= 1'b0;
        end else begin
            sample_out <= sample_next;
            pwm_cnt    <= pwm_cnt + OUT_WIDTH'(1);
            pwm_out    <= (sample_out > pwm_cnt);
        end
    end

endmodule

// File: tb/tb_bitslam_synth.sv
// Directed testbench for bitslam_synth: a default instance (OUT_WIDTH=5)
// and a narrow-output instance (OUT_WIDTH=4) share one bus.
module tb_bitslam_synth;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] sample5;
    logic       pwm5;
    logic [3:0] sample4;
    logic       pwm4;
    int         n_checks = 0;
    int         n_fail = 0;
    int         highs;

    bitslam_synth_if bus ();

    bitslam_synth dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .sample_out (sample5),
        .pwm_out    (pwm5)
    );

    bitslam_synth #(.OUT_WIDTH(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .sample_out (sample4),
        .pwm_out    (pwm4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns on the negedge right after the data edge.
    task automatic wr(input logic [5:0] a, input logic [5:0] d);
        @(negedge clk);
        bus.addr_data_sel = 1'b0;
        bus.addr_data     = a;
        @(negedge clk);
        bus.addr_data_sel = 1'b1;
        bus.addr_data     = d;
        @(negedge clk);
        bus.addr_data_sel = 1'b0;
        bus.addr_data     = a;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.addr_data_sel = 1'b0;
        bus.addr_data     = 6'h00;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic count_pwm(input int n, output int h);
        h = 0;
        for (int i = 0; i < n; i++) begin
            if (pwm5) h++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.addr_data_sel = 1'b0;
        bus.addr_data     = 6'h00;
        repeat (3) @(negedge clk);
        check("rst_sample", int'(sample5), 0);
        check("rst_pwm", int'(pwm5), 0);
        check("rst_sample4", int'(sample4), 0);
        reset = 1'b0;

        // Square, div 3, duty 0x20: 512 clocks high, 512 low.
        wr(6'h00, 6'd3);
        wr(6'h01, 6'd15);
        wr(6'h02, 6'd2);
        check("t1_latency", int'(sample5), 0);
        @(negedge clk);
        check("t1_first_high", int'(sample5), 15);
        repeat (98) @(negedge clk);
        count_pwm(32, highs);
        check("t1_pwm_15of32", highs, 15);
        repeat (381) @(negedge clk);
        check("t1_last_high", int'(sample5), 15);
        @(negedge clk);
        check("t1_first_low", int'(sample5), 0);
        @(negedge clk);
        count_pwm(400, highs);
        check("t1_pwm_zero", highs, 0);
        repeat (110) @(negedge clk);
        check("t1_last_low", int'(sample5), 0);
        @(negedge clk);
        check("t1_wrap_high", int'(sample5), 15);

        // Duty 8: 128 clocks high out of 1024.
        do_reset();
        wr(6'h03, 6'd8);
        wr(6'h00, 6'd3);
        wr(6'h01, 6'd15);
        wr(6'h02, 6'd2);
        repeat (128) @(negedge clk);
        check("t2_last_high", int'(sample5), 15);
        @(negedge clk);
        check("t2_first_low", int'(sample5), 0);
        repeat (895) @(negedge clk);
        check("t2_last_low", int'(sample5), 0);
        @(negedge clk);
        check("t2_wrap_high", int'(sample5), 15);

        // Noise, tick every clock, volume 1.
        do_reset();
        wr(6'h01, 6'd1);
        wr(6'h02, 6'd3);
        @(negedge clk);
        check("t3_n0", int'(sample5), 1);
        @(negedge clk);
        check("t3_n1", int'(sample5), 0);
        @(negedge clk);
        check("t3_n2", int'(sample5), 0);
        repeat (12) @(negedge clk);
        check("t3_n14", int'(sample5), 1);
        @(negedge clk);
        check("t3_n15", int'(sample5), 1);
        @(negedge clk);
        check("t3_n16", int'(sample5), 0);
        repeat (32750) @(negedge clk);
        check("t3_n32766", int'(sample5), 0);
        @(negedge clk);
        check("t3_n32767", int'(sample5), 1);
        @(negedge clk);
        check("t3_n32768", int'(sample5), 0);

        // Two voices, div 0; voice0 enabled 3 clocks before voice1.
        do_reset();
        wr(6'h01, 6'd15);
        wr(6'h05, 6'd15);
        wr(6'h02, 6'd2);
        wr(6'h06, 6'd2);
        check("t4_one_voice", int'(sample5), 15);
        check("t4_one_voice4", int'(sample4), 15);
        @(negedge clk);
        check("t4_sum30", int'(sample5), 30);
        check("t4_sat15", int'(sample4), 15);
        repeat (125) @(negedge clk);
        check("t4_v1_only", int'(sample5), 15);
        repeat (3) @(negedge clk);
        check("t4_both_low", int'(sample5), 0);
        check("t4_both_low4", int'(sample4), 0);

        // Writes to voice 5 must do nothing; then sample 8 -> PWM 8/32.
        do_reset();
        wr(6'h14, 6'h3F);
        wr(6'h15, 6'd15);
        wr(6'h16, 6'd2);
        repeat (2) @(negedge clk);
        check("t5_ignored", int'(sample5), 0);
        wr(6'h03, 6'd63);
        wr(6'h00, 6'd63);
        wr(6'h01, 6'd8);
        wr(6'h02, 6'd2);
        @(negedge clk);
        check("t5_sample8", int'(sample5), 8);
        repeat (10) @(negedge clk);
        count_pwm(32, highs);
        check("t5_pwm_8of32", highs, 8);
        repeat (200) @(negedge clk);

        // Reset mid-tone with a mode write on the reset edge.
        @(negedge clk);
        reset = 1'b1;
        bus.addr_data_sel = 1'b1;
        bus.addr_data     = 6'd2;
        @(negedge clk);
        reset = 1'b0;
        bus.addr_data_sel = 1'b0;
        bus.addr_data     = 6'h02;
        check("t6_rst_sample", int'(sample5), 0);
        check("t6_rst_pwm", int'(pwm5), 0);
        wr(6'h01, 6'd5);
        @(negedge clk);
        check("t6_write_dropped", int'(sample5), 0);
        wr(6'h02, 6'd2);
        @(negedge clk);
        check("t6_first_high", int'(sample5), 5);
        repeat (127) @(negedge clk);
        check("t6_last_high", int'(sample5), 5);
        @(negedge clk);
        check("t6_first_low", int'(sample5), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
